// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared defaults, player state type and address-width helpers
//            for the FIR stimulus player / capture engine.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int c_BIT_PREC = 16;
    localparam int c_OUT_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } player_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int fir_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int fir_aw(input int nch, input int depth);
        return fir_cw(nch * depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_stream_player_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_stream_player_if
// Brief    : Host/config, FIR-side and capture readback signals of the player.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_stream_player_if
    import fir_pkg::*;
#(
    parameter int BIT_PREC = c_BIT_PREC,
    parameter int OUT_SIZE = c_OUT_SIZE,
    parameter int NCH      = 2,
    parameter int DEPTH    = 256
);
    localparam int AW = fir_aw(NCH, DEPTH);
    localparam int CW = fir_cw(NCH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                cfg_wr_en;
    logic [AW-1:0]       cfg_addr;
    logic [BIT_PREC-1:0] cfg_wdata;
    logic [LW-1:0]       cfg_len;
    logic                loop;
    logic                start;
    logic                stop;
    logic                busy;
    logic                done;
    logic                fir_en;
    logic [CW-1:0]       fir_ch;
    logic [BIT_PREC-1:0] in_wave;
    logic [OUT_SIZE-1:0] out_wave;
    logic [AW-1:0]       cap_addr;
    logic [OUT_SIZE-1:0] cap_rdata;
    logic                cap_wrap;

    // Host side: configures, starts, models the FIR and reads captures.
    modport master (
        output cfg_wr_en, cfg_addr, cfg_wdata, cfg_len, loop, start, stop,
        output out_wave, cap_addr,
        input  busy, done, fir_en, fir_ch, in_wave, cap_rdata, cap_wrap
    );

    modport slave (
        input  cfg_wr_en, cfg_addr, cfg_wdata, cfg_len, loop, start, stop,
        input  out_wave, cap_addr,
        output busy, done, fir_en, fir_ch, in_wave, cap_rdata, cap_wrap
    );

endinterface
`default_nettype wire

// File: rtl/fir_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : fir_sdp_ram
// Brief    : Simple dual-port RAM, registered read; read-during-write to the
//            same address returns the old word.
// Revision : 1.0 - initial release
// ============================================================================
module fir_sdp_ram
    import fir_pkg::*;
#(
    parameter int WIDTH = c_BIT_PREC,
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [WORDS];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array itself is never cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fir_stream_player.sv
`default_nettype none
// ============================================================================
// Module   : fir_stream_player
// Brief    : Plays channel-interleaved stimulus into the FIR and captures its
//            outputs at a fixed latency into a readback buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fir_stream_player
    import fir_pkg::*;
#(
    parameter int BIT_PREC = c_BIT_PREC,
    parameter int OUT_SIZE = c_OUT_SIZE,
    parameter int NCH      = 2,
    parameter int DEPTH    = 256,
    parameter int LAT      = 2
) (
    input  logic               clk,
    input  logic               rst,
    fir_stream_player_if.slave bus
);

    localparam int AW  = fir_aw(NCH, DEPTH);
    localparam int CW  = fir_cw(NCH);
    localparam int IW  = fir_cw(DEPTH);
    localparam int LW  = $clog2(DEPTH) + 1;
    localparam int DCW = $clog2(LAT + 1);
    localparam logic [CW-1:0] c_LAST_CH = CW'(NCH - 1);

    player_state_t  r_state;
    logic [IW-1:0]  r_i;
    logic [IW-1:0]  r_last_i;
    logic [CW-1:0]  r_c;
    logic [AW-1:0]  r_addr;
    logic [DCW-1:0] r_drain_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_fir_en;
    logic [CW-1:0]  r_fir_ch;
    logic           r_cap_wrap;
    logic [LAT-1:0] r_pv;
    logic [AW-1:0]  r_pa [LAT];

    logic           w_active;
    logic           w_issue;
    logic           w_last;
    logic [LW-1:0]  w_len;

    assign w_active = (r_state == PLAY) || (r_state == DRAIN);
    // Every PLAY cycle reads one stimulus word; the RAM output register is in_wave.
    assign w_issue  = (r_state == PLAY);
    assign w_last   = (r_i == r_last_i) && (r_c == c_LAST_CH);
    assign w_len    = (bus.cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.cfg_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_last_i    <= '0;
            r_c         <= '0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fir_en    <= 1'b0;
            r_fir_ch    <= '0;
            r_cap_wrap  <= 1'b0;
        end else begin
            r_fir_en <= w_issue;
            if (w_issue) begin
                r_fir_ch <= r_c;
            end
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_i        <= '0;
                        r_c        <= '0;
                        r_addr     <= '0;
                        r_last_i   <= IW'(w_len - LW'(1));
                        r_cap_wrap <= 1'b0;
                        if (w_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= PLAY;
                            r_done  <= 1'b0;
                        end
                    end
                end
                PLAY: begin
                    r_busy <= 1'b1;
                    if (w_last && bus.loop && !bus.stop) begin
                        r_i        <= '0;
                        r_c        <= '0;
                        r_addr     <= '0;
                        r_cap_wrap <= 1'b1;
                    end else if (w_last || bus.stop) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= DCW'(LAT);
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        if (r_c == c_LAST_CH) begin
                            r_c <= '0;
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_c <= r_c + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Wait until the last in-flight output has been written.
                    if (r_drain_cnt == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stage 0 loads alongside fir_en, so stage LAT-1 lines up with out_wave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int j = 0; j < LAT; j++) begin
                r_pa[j] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pa[0] <= r_addr;
            for (int j = 1; j < LAT; j++) begin
                r_pv[j] <= r_pv[j-1];
                r_pa[j] <= r_pa[j-1];
            end
        end
    end

    fir_sdp_ram #(
        .WIDTH (BIT_PREC),
        .WORDS (NCH * DEPTH),
        .AW    (AW)
    ) u_stim_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.cfg_wr_en && !w_active),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_wdata),
        .re    (w_issue),
        .raddr (r_addr),
        .rdata (bus.in_wave)
    );

    fir_sdp_ram #(
        .WIDTH (OUT_SIZE),
        .WORDS (NCH * DEPTH),
        .AW    (AW)
    ) u_cap_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (r_pv[LAT-1]),
        .waddr (r_pa[LAT-1]),
        .wdata (bus.out_wave),
        .re    (1'b1),
        .raddr (bus.cap_addr),
        .rdata (bus.cap_rdata)
    );

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.fir_en   = r_fir_en;
    assign bus.fir_ch   = r_fir_ch;
    assign bus.cap_wrap = r_cap_wrap;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_stream_player
// Brief    : Self-checking bench for fir_stream_player with a doubling FIR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_stream_player;
    import fir_pkg::*;

    localparam int BIT_PREC = 16;
    localparam int OUT_SIZE = 32;
    localparam int NCH      = 2;
    localparam int DEPTH    = 16;
    localparam int LAT      = 2;
    localparam int AW       = fir_aw(NCH, DEPTH);
    localparam int LW       = $clog2(DEPTH) + 1;
    localparam int NW       = NCH * DEPTH;

    typedef struct {
        int len;
        bit lp;
        int stop_at;
        bit ramp;
        int exp_cnt;
        int exp_done;
        bit exp_wrap;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [BIT_PREC-1:0] stim_m [NW];
    vec_t tbl [7];

    always #5 clk = ~clk;

    fir_stream_player_if #(
        .BIT_PREC (BIT_PREC), .OUT_SIZE (OUT_SIZE), .NCH (NCH), .DEPTH (DEPTH)
    ) bus ();

    fir_stream_player #(
        .BIT_PREC (BIT_PREC), .OUT_SIZE (OUT_SIZE), .NCH (NCH), .DEPTH (DEPTH), .LAT (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FIR model: out = 2*in, seen by the player LAT edges after the sample.
    always @(posedge clk) begin
        bus.out_wave <= bus.fir_en ? ({16'd0, bus.in_wave} << 1) : 32'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic write_stim(input int a, input logic [BIT_PREC-1:0] d);
        bus.cfg_wr_en = 1'b1;
        bus.cfg_addr  = AW'(a);
        bus.cfg_wdata = d;
        tick();
        bus.cfg_wr_en = 1'b0;
        stim_m[a] = d;
    endtask

    task automatic fill_stim(input bit ramp);
        for (int j = 0; j < NW; j++) begin
            write_stim(j, ramp ? BIT_PREC'(j + 1) : BIT_PREC'($urandom));
        end
    endtask

    task automatic run(input string tag, input int len, input bit lp, input int stop_at,
                       input int lock_at, input int exp_cnt, input int exp_done,
                       input bit exp_wrap);
        int eff, n, cnt, mdone, done_t, issued, a;
        bit seen;
        eff = (len > DEPTH) ? DEPTH : len;
        n   = eff * NCH;
        if (eff == 0)                           cnt = 0;
        else if (lp)                            cnt = stop_at;
        else if (stop_at != 0 && stop_at < n)   cnt = stop_at;
        else                                    cnt = n;
        mdone = (eff == 0) ? 1 : cnt + LAT + 1;

        bus.cfg_len = LW'(len);
        bus.loop    = lp;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;

        issued = 0;
        seen   = 1'b0;
        done_t = 0;
        for (int t = 1; t <= exp_done + 20 && !seen; t++) begin
            bus.stop = (t == stop_at);
            if (t == lock_at) begin
                bus.start     = 1'b1;
                bus.cfg_wr_en = 1'b1;
                bus.cfg_addr  = AW'(n - 1);
                bus.cfg_wdata = ~stim_m[n - 1];
            end
            tick();
            bus.stop      = 1'b0;
            bus.start     = 1'b0;
            bus.cfg_wr_en = 1'b0;

            check({tag, ".fir_en"}, bus.fir_en, (t <= cnt));
            check({tag, ".busy"}, bus.busy, (eff != 0) && (t < mdone));
            if (t <= cnt) begin
                a = (t - 1) % n;
                check({tag, ".fir_ch"}, bus.fir_ch, a % NCH);
                check({tag, ".in_wave"}, bus.in_wave, stim_m[a]);
            end
            if (bus.fir_en) issued++;
            if (bus.done) begin
                seen   = 1'b1;
                done_t = t;
            end
        end
        check({tag, ".count"}, issued, exp_cnt);
        check({tag, ".done_at"}, done_t, exp_done);
        check({tag, ".cap_wrap"}, bus.cap_wrap, exp_wrap);

        for (int k = 0; k < ((cnt < n) ? cnt : n); k++) begin
            bus.cap_addr = AW'(k);
            tick();
            check({tag, ".capture"}, bus.cap_rdata, {16'd0, stim_m[k]} << 1);
        end
    endtask

    initial begin
        //            len     lp  stop  ramp cnt done wrap
        tbl[0] = '{4,         0,  0,    1,   8,  11,  0};
        tbl[1] = '{0,         0,  0,    0,   0,  1,   0};
        tbl[2] = '{3,         1,  10,   0,   10, 13,  1};
        tbl[3] = '{DEPTH + 5, 0,  0,    0,   32, 35,  0};
        tbl[4] = '{5,         0,  3,    0,   3,  6,   0};
        tbl[5] = '{2,         1,  4,    0,   4,  7,   0};
        tbl[6] = '{1,         0,  0,    0,   2,  5,   0};

        n_vec = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.cfg_wr_en = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.cfg_len   = '0;
        bus.loop      = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cap_addr  = '0;
        repeat (3) tick();
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.fir_en", bus.fir_en, 0);
        check("rst.fir_ch", bus.fir_ch, 0);
        check("rst.in_wave", bus.in_wave, 0);
        check("rst.cap_wrap", bus.cap_wrap, 0);
        check("rst.cap_rdata", bus.cap_rdata, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            fill_stim(tbl[i].ramp);
            run($sformatf("v%0d", i), tbl[i].len, tbl[i].lp, tbl[i].stop_at, 0,
                tbl[i].exp_cnt, tbl[i].exp_done, tbl[i].exp_wrap);
        end

        // Second start and a stimulus write while busy must both be dropped.
        fill_stim(1'b0);
        run("lock", 8, 1'b0, 0, 3, 16, 19, 1'b0);

        // Asynchronous reset in the middle of a looped run.
        bus.cfg_len = LW'(4);
        bus.loop    = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("midrst.pre_fir_en", bus.fir_en, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst.async_fir_en", bus.fir_en, 0);
        check("midrst.async_busy", bus.busy, 0);
        tick();
        check("midrst.fir_en", bus.fir_en, 0);
        check("midrst.busy", bus.busy, 0);
        check("midrst.done", bus.done, 0);
        check("midrst.cap_wrap", bus.cap_wrap, 0);
        rst = 1'b0;
        tick();
        run("replay", 4, 1'b0, 0, 0, 8, 11, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
